// File: rtl/bwe_pkg.sv
// Shared definitions for the bandwidth-estimation probe path (tx and rx).
// Holds the default train parameters, the counter width and the tx state enum.
package bwe_pkg;

  localparam int unsigned PKT_NUMBER_DEF   = 3;
  localparam int unsigned SENDER_IPD_DEF   = 10;
  localparam int unsigned TOTAL_CYCLES_DEF = 162;
  localparam int unsigned CNT_W            = 32;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DUE  = 3'd1,
    ST_GAP  = 3'd2,
    ST_HOLD = 3'd3,
    ST_FIN  = 3'd4
  } state_e;

endpackage

// File: rtl/ipd_timer.sv
// ipd_timer: loadable/clearable up-counter with a terminal-compare flag.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   clr          force count to 0 (highest priority)
//   load         load load_val
//   load_val     value loaded on load
//   en           increment by one
//   term         terminal value
//   tc           count currently equals term
module ipd_timer #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (load) cnt_d = load_val;
    else if (en)   cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == term);

endmodule

// File: rtl/bwe_probe_tx.sv
// bwe_probe_tx: transmit end of the bandwidth-estimation probe path.
// On start, emits PKT_NUMBER one-cycle pktSend strobes SENDER_IPD cycles
// apart. A packet due while txReady is low is held (counted late); later
// packets are spaced from the actual strobe. The train aborts with
// done+timeout once the train timer reaches TOTAL_CYCLES.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   start        train request, sampled in IDLE only
//   txReady      channel accepts a packet this cycle
//   pktSend      packet strobe (only with txReady)
//   busy         train in progress
//   done         one-cycle end-of-train pulse
//   timeout      one-cycle pulse with done on abort
//   sentCnt      packets sent in current/last train
//   lateCnt      packets sent after their due cycle
module bwe_probe_tx import bwe_pkg::*; #(
  parameter int unsigned PKT_NUMBER   = PKT_NUMBER_DEF,
  parameter int unsigned SENDER_IPD   = SENDER_IPD_DEF,
  parameter int unsigned TOTAL_CYCLES = TOTAL_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             txReady,
  output logic             pktSend,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] sentCnt,
  output logic [CNT_W-1:0] lateCnt
);

  localparam cnt_t LAST_IDX = cnt_t'(PKT_NUMBER - 1);
  localparam cnt_t BUDGET   = cnt_t'(TOTAL_CYCLES);
  localparam cnt_t GAP_TERM = cnt_t'(SENDER_IPD - 1);

  state_e state_q, state_d;
  cnt_t   sent_q, sent_d;
  cnt_t   late_q, late_d;
  cnt_t   tmr_q, tmr_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   to_q, to_d;

  logic   send;
  logic   abort;
  logic   gap_clr, gap_load, gap_en, gap_tc;

  ipd_timer #(.W(CNT_W)) u_gap (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (gap_clr),
    .load     (gap_load),
    .load_val (cnt_t'(1)),
    .en       (gap_en),
    .term     (GAP_TERM),
    .tc       (gap_tc)
  );

  // Budget is hit at the edge where the timer would reach TOTAL_CYCLES;
  // done/timeout then show in the following cycle with the timer at budget.
  assign abort = (state_q inside {ST_DUE, ST_GAP, ST_HOLD}) &&
                 ((tmr_q + cnt_t'(1)) == BUDGET);

  always_comb begin
    state_d  = state_q;
    sent_d   = sent_q;
    late_d   = late_q;
    tmr_d    = tmr_q;
    done_d   = 1'b0;
    to_d     = 1'b0;
    send     = 1'b0;
    gap_clr  = 1'b0;
    gap_load = 1'b0;
    gap_en   = 1'b0;

    if (state_q != ST_IDLE) tmr_d = tmr_q + cnt_t'(1);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sent_d  = '0;
          late_d  = '0;
          // the accept cycle is the first counted train cycle
          tmr_d   = cnt_t'(1);
          gap_clr = 1'b1;
          state_d = ST_DUE;
        end
      end
      ST_DUE, ST_HOLD: begin
        if (abort) begin
          done_d  = 1'b1;
          to_d    = 1'b1;
          state_d = ST_IDLE;
        end else if (txReady) begin
          send   = 1'b1;
          sent_d = sent_q + cnt_t'(1);
          if (state_q == ST_HOLD) late_d = late_q + cnt_t'(1);
          if (sent_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = ST_FIN;
          end else begin
            gap_load = 1'b1;
            state_d  = ST_GAP;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_GAP: begin
        if (abort) begin
          done_d  = 1'b1;
          to_d    = 1'b1;
          state_d = ST_IDLE;
        end else if (gap_tc) begin
          state_d = ST_DUE;
        end else begin
          gap_en = 1'b1;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sent_q  <= '0;
      late_q  <= '0;
      tmr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sent_q  <= sent_d;
      late_q  <= late_d;
      tmr_q   <= tmr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      to_q    <= to_d;
    end
  end

  // The strobe must coincide with txReady in the same cycle, so it is
  // decoded from the state register qualified by txReady.
  assign pktSend = send;
  assign busy    = busy_q;
  assign done    = done_q;
  assign timeout = to_q;
  assign sentCnt = sent_q;
  assign lateCnt = late_q;

endmodule

// File: tb/tb_bwe_probe_tx.sv
module tb_bwe_probe_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start1 = 1'b0;
  logic        txReady = 1'b1;
  logic        pkt_send, busy, done, timeout;
  logic [31:0] sent_cnt, late_cnt;
  logic        pkt_send1, busy1, done1, timeout1;
  logic [31:0] sent_cnt1, late_cnt1;

  always #5 clk = ~clk;

  bwe_probe_tx dut (
    .clk(clk), .rst_n(rst_n), .start(start), .txReady(txReady),
    .pktSend(pkt_send), .busy(busy), .done(done), .timeout(timeout),
    .sentCnt(sent_cnt), .lateCnt(late_cnt)
  );

  bwe_probe_tx #(.PKT_NUMBER(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .txReady(txReady),
    .pktSend(pkt_send1), .busy(busy1), .done(done1), .timeout(timeout1),
    .sentCnt(sent_cnt1), .lateCnt(late_cnt1)
  );

  typedef struct {
    int start_cyc;
    int lo_from;
    int lo_to;
    int npk;
    int pk[3];
    int done_cyc;
    bit to;
    int sent;
    int late;
  } vec_t;

  typedef struct {
    int cyc;
    bit to;
    int sent;
    int late;
  } dexp_t;

  vec_t  vecs[4];
  int    pkt_q[$];
  dexp_t done_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic push_train(input int s, input int gap1, input int gap2);
    dexp_t d;
    pkt_q.push_back(s + 1);
    pkt_q.push_back(s + 1 + gap1);
    pkt_q.push_back(s + 1 + gap1 + gap2);
    d.cyc = s + 2 + gap1 + gap2; d.to = 1'b0; d.sent = 3; d.late = 0;
    done_q.push_back(d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0; txReady = 1'b1;
    pkt_q.delete(); done_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  // One cycle c: drive inputs after the edge, check outputs on the falling edge.
  task automatic step(input int c, input logic st, input logic rdy);
    int    e;
    dexp_t d;
    @(posedge clk); #1;
    start = st; txReady = rdy;
    @(negedge clk);
    if (pkt_send) begin
      chk("pkt_needs_ready", rdy, 1);
      if (pkt_q.size() == 0) chk("pkt_unexpected_cycle", c, -1);
      else begin e = pkt_q.pop_front(); chk("pkt_cycle", c, e); end
    end
    if (done) begin
      if (done_q.size() == 0) chk("done_unexpected_cycle", c, -1);
      else begin
        d = done_q.pop_front();
        chk("done_cycle", c, d.cyc);
        chk("done_timeout", timeout, d.to);
        chk("done_sentCnt", sent_cnt, d.sent);
        chk("done_lateCnt", late_cnt, d.late);
      end
    end
    if (timeout && !done) chk("timeout_without_done", 1, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dexp_t d;
    vecs[0] = '{start_cyc:5, lo_from:-1, lo_to:-2,   npk:3, pk:'{6, 16, 26},
                done_cyc:27,  to:0, sent:3, late:0};
    vecs[1] = '{start_cyc:5, lo_from:16, lo_to:19,   npk:3, pk:'{6, 20, 30},
                done_cyc:31,  to:0, sent:3, late:1};
    vecs[2] = '{start_cyc:5, lo_from:6,  lo_to:1000, npk:0, pk:'{0, 0, 0},
                done_cyc:167, to:1, sent:0, late:0};
    vecs[3] = '{start_cyc:5, lo_from:6,  lo_to:8,    npk:3, pk:'{9, 19, 29},
                done_cyc:30,  to:0, sent:3, late:1};

    // reset state
    do_reset();
    chk("rst_pktSend", pkt_send, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_sentCnt", sent_cnt, 0);
    chk("rst_lateCnt", late_cnt, 0);
    chk("rst_busy1", busy1, 0);

    // table-driven trains
    for (int i = 0; i < 4; i++) begin
      do_reset();
      for (int c = 0; c <= vecs[i].done_cyc + 2; c++) begin
        if (c == vecs[i].start_cyc) begin
          for (int k = 0; k < vecs[i].npk; k++) pkt_q.push_back(vecs[i].pk[k]);
          d.cyc = vecs[i].done_cyc; d.to = vecs[i].to;
          d.sent = vecs[i].sent; d.late = vecs[i].late;
          done_q.push_back(d);
        end
        step(c, c == vecs[i].start_cyc,
             !(c >= vecs[i].lo_from && c <= vecs[i].lo_to));
        if (c == vecs[i].done_cyc + 1) chk("busy_after_done", busy, 0);
      end
      chk("pkt_left", pkt_q.size(), 0);
      chk("done_left", done_q.size(), 0);
    end

    // start while busy is ignored; start in IDLE right after FIN is taken
    do_reset();
    for (int c = 0; c <= 55; c++) begin
      if (c == 5 || c == 28) push_train(c, 10, 10);
      step(c, (c == 5) || (c == 10) || (c == 27) || (c == 28), 1'b1);
      if (c == 29) begin
        chk("restart_sentCnt_cleared", sent_cnt, 0);
        chk("restart_lateCnt_cleared", late_cnt, 0);
      end
      if (c == 51) chk("restart_busy_end", busy, 0);
    end
    chk("restart_pkt_left", pkt_q.size(), 0);
    chk("restart_done_left", done_q.size(), 0);

    // asynchronous reset in the middle of a gap
    do_reset();
    push_train(5, 10, 10);
    for (int c = 0; c <= 17; c++) step(c, c == 5, 1'b1);
    @(posedge clk); #1;
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_sentCnt", sent_cnt, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pktSend", pkt_send, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_timeout", timeout, 0);
    chk("async_rst_sentCnt", sent_cnt, 0);
    chk("async_rst_lateCnt", late_cnt, 0);
    pkt_q.delete(); done_q.delete();
    @(negedge clk) rst_n = 1'b1;
    for (int c = 19; c <= 59; c++) begin
      step(c, 1'b0, 1'b1);
      if (c == 40) chk("post_rst_busy", busy, 0);
    end

    // single-packet train
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      @(posedge clk); #1;
      start1 = (c == 3); txReady = 1'b1;
      @(negedge clk);
      chk("p1_pktSend", pkt_send1, (c == 4));
      chk("p1_done", done1, (c == 5));
      chk("p1_busy", busy1, (c == 4 || c == 5));
      chk("p1_timeout", timeout1, 0);
      if (c == 5) chk("p1_sentCnt", sent_cnt1, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
